// File: rtl/idli_trace_m.sv
// idli_trace_m: instruction-trace capture unit for the idli core.
// Reassembles the nibble-serial PC seen by the execution unit. On each retire
// it forms a {seq, skip, pc} record and pushes the record into a small FIFO.
// A debug host drains the FIFO over a valid/ready port. Capture can be held
// off until a PC match trigger fires. When the FIFO is full, it either stops
// or overwrites the oldest record.
module idli_trace_m #(
    parameter int PC_W      = 16,
    parameter int SLICE_W   = 4,
    parameter int PC_OFFSET = 1,
    parameter int SEQ_W     = 8,
    parameter int DEPTH     = 8
) (
    input  logic                         gck,
    input  logic                         rst_n,
    input  logic                         i_ex_en,
    input  logic [SLICE_W-1:0]           i_pc_slice,
    input  logic                         i_instr_done,
    input  logic                         i_instr_skip,
    input  logic                         i_wrap,
    input  logic                         i_trig_en,
    input  logic [PC_W-1:0]              i_trig_pc,
    input  logic                         i_clr,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [SEQ_W+PC_W:0]          o_rec,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic                         o_triggered
);

    localparam int REC_W = SEQ_W + 1 + PC_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  pc_q,     pc_d;
    logic [SEQ_W-1:0] seq_q,    seq_d;
    logic             trig_q,   trig_d;
    logic             ovf_q,    ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [REC_W-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Datapath: PC assembly, retire qualification, trigger
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  pc_shift;
    logic [PC_W-1:0]  rec_pc;
    logic [REC_W-1:0] rec_d;
    logic             retire;
    logic             match;
    logic             triggered;
    logic             capture;
    logic             full;
    logic             pop;
    logic             mem_we;
    logic             rd_adv;

    // A new slice enters at the top. Older slices move toward the LSB, so
    // after PC_W/SLICE_W enabled cycles the whole PC has been assembled.
    // A shift is used instead of a part-select so that SLICE_W == PC_W
    // also works.
    assign pc_shift = (pc_q >> SLICE_W) | (PC_W'(i_pc_slice) << (PC_W - SLICE_W));

    // The execution unit sees the PC one step ahead of the retiring
    // instruction. The offset is removed here, and the result wraps
    // modulo 2^PC_W.
    assign rec_pc    = pc_shift - PC_W'(PC_OFFSET);

    // Cycles in which the core clock is gated off are ignored.
    assign retire    = i_instr_done && i_ex_en;
    assign match     = retire && (rec_pc == i_trig_pc);
    assign triggered = trig_q || !i_trig_en;

    // The instruction that fires the trigger is itself captured.
    assign capture   = retire && (triggered || match);

    assign rec_d     = {seq_q, i_instr_skip, rec_pc};
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop       = o_valid && i_ready;

    // PC and sequence next-state. i_clr does not affect either of them.
    always_comb begin
        // NOTE: every variable that always_comb writes gets a default
        // first. Otherwise a path that does not assign it infers a latch.
        pc_d  = pc_q;
        seq_d = seq_q;
        if (i_ex_en) begin
            pc_d = pc_shift;
        end
        if (retire) begin
            seq_d = seq_q + SEQ_W'(1);
        end
    end

    // FIFO control, overflow flag and trigger next-state. i_clr wins.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        trig_d   = trig_q;
        mem_we   = 1'b0;
        rd_adv   = 1'b0;
        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            trig_d   = 1'b0;
        end else begin
            if (match) begin
                trig_d = 1'b1;
            end
            // A write is accepted if there is room. It is also accepted
            // when a pop frees a slot in the same cycle, or in wrap mode,
            // where it overwrites the oldest record.
            mem_we = capture && (!full || pop || i_wrap);
            // In wrap mode with no pop, the head advances past the
            // overwritten entry.
            rd_adv = pop || (capture && full && i_wrap);
            if (capture && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (mem_we) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (mem_we && !rd_adv) begin
                count_d = count_q + CNT_W'(1);
            end else if (!mem_we && rd_adv) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control and context registers, asynchronously reset.
    always_ff @(posedge gck or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments. All
        // registers then sample their inputs at the same edge,
        // regardless of the order of the statements.
        if (!rst_n) begin
            pc_q     <= '0;
            seq_q    <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            seq_q    <= seq_d;
            trig_q   <= trig_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage, written at the tail.
    always_ff @(posedge gck) begin
        // NOTE: the storage array is deliberately not reset. Its contents
        // are only observed when count_q says an entry is valid, and
        // leaving out the reset lets the array map onto plain storage
        // cells.
        if (mem_we) begin
            mem_q[wr_ptr_q] <= rec_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all outputs come from registers. No combinational path
    // leads from the PC slice to an output.
    // ------------------------------------------------------------------
    assign o_valid     = (count_q != '0);
    assign o_rec       = mem_q[rd_ptr_q];
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_triggered = triggered;

endmodule

// File: doc/idli_trace_m.md
# idli_trace_m

Synthesisable instruction-trace capture unit for the idli core. It reassembles the nibble-serial PC fed to the execution unit, forms a trace record each time an instruction retires, and buffers records in a parametrised FIFO for draining by a debug host over a valid/ready port. It generalises the bench-only PC/retire probing into a reusable block with configurable width, depth, overflow mode and a PC-match trigger. It sits beside `idli_ex_m`, taps its PC slice and retire strobes, and runs on the ungated core clock.

## Interface
- `PC_W`, 16: PC width in bits.
- `SLICE_W`, 4: PC bits delivered per execution cycle; must divide `PC_W`.
- `PC_OFFSET`, 1: constant subtracted from the assembled PC to compensate for pipeline lead.
- `SEQ_W`, 8: retire sequence counter width.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `gck` in 1: ungated core clock; all state on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_ex_en` in 1: execution clock enabled this cycle (sync gate not asserted).
- `i_pc_slice` in `SLICE_W`: PC slice entering execution, LSB slice first.
- `i_instr_done` in 1: instruction completes this cycle.
- `i_instr_skip` in 1: completing instruction was predicated off.
- `i_wrap` in 1: 0 = stop-when-full, 1 = overwrite oldest.
- `i_trig_en` in 1: capture is held off until PC match.
- `i_trig_pc` in `PC_W`: trigger PC (compared after offset).
- `i_clr` in 1: synchronous flush of FIFO, overflow flag and trigger state.
- `o_valid` out 1: head record available.
- `i_ready` in 1: host accepts head record.
- `o_rec` out `SEQ_W+1+PC_W`: `{seq, skip, pc}`.
- `o_count` out `$clog2(DEPTH+1)`: records held.
- `o_overflow` out 1: sticky, a record was dropped or overwritten.
- `o_triggered` out 1: trigger has fired (or `i_trig_en` low).

## Operation
- PC assembly: `pc_d = {i_pc_slice, pc_q[PC_W-1:SLICE_W]}`; `pc_q <= pc_d` only when `i_ex_en`. Record PC = `pc_d - PC_OFFSET`, modulo 2^`PC_W`.
- Retire event = `i_instr_done && i_ex_en`. Retire events with `i_ex_en` low are ignored entirely.
- `seq_q` increments (wraps modulo 2^`SEQ_W`) on every retire event, captured or not; record carries the pre-increment value.
- Trigger: `trig_q` resets to 0. `o_triggered = trig_q || !i_trig_en`. On a retire event with record PC == `i_trig_pc`, `trig_q <= 1`; that instruction is itself captured. A retire event is captured iff `o_triggered` or the match occurs in that same cycle.
- Write: captured record written at tail.
- Read: pop when `o_valid && i_ready`; `o_rec` is head entry, undefined-but-stable when `o_valid` low.
- Full, `i_wrap=0`: write dropped, `o_overflow <= 1`, unless a pop occurs in the same cycle, in which case the write is accepted and the count is unchanged.
- Full, `i_wrap=1`, no pop: oldest overwritten, head advances, count stays `DEPTH`, `o_overflow <= 1`. Full with pop and write: normal pop and push, no overflow.
- Empty with write and `i_ready`: no bypass; record appears next cycle.
- `i_clr`: pointers, count, `o_overflow` and `trig_q` cleared; `seq_q` and `pc_q` preserved; any same-cycle write or pop is discarded. `i_clr` has priority over all other events.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing
- Reset values: `o_valid` 0, `o_count` 0, `o_overflow` 0, `trig_q` 0, `seq_q` 0, `pc_q` 0; FIFO storage is not reset.
- Capture latency: retire in cycle N → `o_valid`/`o_count` updated in cycle N+1.
- Pop in cycle N → next head visible, count decremented, in N+1.
- Reset asserted mid-operation: all of the above return to reset values immediately; no partial record survives.
- `o_rec` is driven from registered storage and head pointer; there is no combinational path from `i_pc_slice` to outputs.

## Test plan
- Basic capture: with `i_trig_en=0` and `i_wrap=0`, feed slices 4,3,2,1 (PC 0x1234) and retire on the 4th enabled cycle → next cycle `o_valid=1`, `o_rec={0x00,0,0x1233}`, `o_count=1`. After pop, `o_valid=0`.
- Gating: same stream with `i_ex_en=0` on cycle 2 and that slice repeated later → assembled PC is unaffected; a retire with `i_ex_en=0` produces no record and `seq_q` does not increment.
- Stop mode overflow: 10 retires with `i_ready=0` and `DEPTH=8` → `o_count=8`, `o_overflow=1`. Draining yields seq 0..7.
- Wrap mode: same stimulus with `i_wrap=1` → `o_count=8`, `o_overflow=1`. Draining yields seq 2..9.
- Full with simultaneous pop and write in stop mode → count stays 8, `o_overflow` stays 0, and the new record lands at the tail.
- Trigger: `i_trig_en=1`, `i_trig_pc=0x0041`, retire PCs 0x40, 0x41, 0x42 → only 0x41 and 0x42 are captured (seq 1, 2) and `o_triggered` rises after the 0x41 retire. Then `i_clr` → `o_count=0`, `o_overflow=0`, `o_triggered=0`.
